// File: rtl/mod_addsub_serial_pkg.sv
// Shared definitions for the ECC field arithmetic datapath: mode codes,
// FSM encoding, default sizing and the P-256 prime.
package ecc_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 256;
  localparam int DEFAULT_LIMB  = 8;

  localparam logic [255:0] P256_P =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mod_addsub_serial_if.sv
// Request/response bundle between the point-arithmetic controller (master)
// and the serial modular adder/subtractor (slave).
interface mod_addsub_serial_if
  import ecc_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op_sub, a, b, p,
    input  busy, done, result
  );

  modport slave (
    input  start, op_sub, a, b, p,
    output busy, done, result
  );
endinterface

// File: rtl/mod_addsub_serial_limb_addsub.sv
// Combinational LIMB-bit adder/subtractor; cout_o is the carry (add) or
// borrow (sub) out of the limb.
module limb_addsub #(
  parameter int LIMB = 8
) (
  input  logic [LIMB-1:0] x_i,
  input  logic [LIMB-1:0] y_i,
  input  logic            cin_i,
  input  logic            sub_i,
  output logic [LIMB-1:0] r_o,
  output logic            cout_o
);

  logic [LIMB:0] sum_w;

  // The extra top bit is the carry for add and, by two's-complement wrap, the borrow for sub.
  always_comb begin
    sum_w = '0;
    if (sub_i) sum_w = {1'b0, x_i} - {1'b0, y_i} - {{LIMB{1'b0}}, cin_i};
    else       sum_w = {1'b0, x_i} + {1'b0, y_i} + {{LIMB{1'b0}}, cin_i};
  end

  assign r_o    = sum_w[LIMB-1:0];
  assign cout_o = sum_w[LIMB];

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial modular adder/subtractor: S = a (+/-) b and T = S (-/+) p are
// built side by side one limb per cycle; the final carries pick S or T.
module mod_addsub_serial
  import ecc_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LIMB  = DEFAULT_LIMB
) (
  input  logic               clk,
  input  logic               rst_n,
  mod_addsub_serial_if.slave bus
);

  localparam int NL = WIDTH / LIMB;
  localparam int KW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NL - 1);

  if (WIDTH % LIMB != 0) begin : g_bad_limb
    $error("mod_addsub_serial: LIMB must divide WIDTH");
  end

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic             c1_q, c2_q, sub_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, s_q, t_q, result_q;
  logic             busy_q, done_q;

  logic [LIMB-1:0]  s_limb, t_limb;
  logic             c1_d, c2_d, take_t;
  logic [WIDTH-1:0] s_d, t_d, result_d;

  limb_addsub #(.LIMB(LIMB)) u_s_chain (
    .x_i   (a_q[LIMB-1:0]),
    .y_i   (b_q[LIMB-1:0]),
    .cin_i (c1_q),
    .sub_i (sub_q),
    .r_o   (s_limb),
    .cout_o(c1_d)
  );

  // T chain applies the inverse operation with p to the limb S produces this cycle.
  limb_addsub #(.LIMB(LIMB)) u_t_chain (
    .x_i   (s_limb),
    .y_i   (p_q[LIMB-1:0]),
    .cin_i (c2_q),
    .sub_i (~sub_q),
    .r_o   (t_limb),
    .cout_o(c2_d)
  );

  // New limbs enter at the top so limb 0 lands at the bottom after NL shifts.
  assign s_d = {s_limb, s_q} >> LIMB;
  assign t_d = {t_limb, t_q} >> LIMB;

  assign take_t   = (sub_q == OP_SUB) ? c1_d : (c1_d | ~c2_d);
  assign result_d = take_t ? t_d : s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        // FIN accepts a new start just like IDLE, giving back-to-back operation.
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            p_q     <= bus.p;
            sub_q   <= bus.op_sub;
            k_q     <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q  <= a_q >> LIMB;
          b_q  <= b_q >> LIMB;
          p_q  <= p_q >> LIMB;
          s_q  <= s_d;
          t_q  <= t_d;
          c1_q <= c1_d;
          c2_q <= c2_d;
          k_q  <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            result_q <= result_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Bench for mod_addsub_serial: a 16-bit/4-bit-limb instance and a default
// P-256 instance, checked against a plain modular-arithmetic reference.
module tb_mod_addsub_serial;
  import ecc_arith_pkg::*;

  localparam int NL16  = 4;
  localparam int NL256 = DEFAULT_WIDTH / DEFAULT_LIMB;
  localparam logic [15:0] P16 = 16'hFFF1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_addsub_serial_if #(.WIDTH(16))  i16 ();
  mod_addsub_serial_if #(.WIDTH(256)) i256 ();

  mod_addsub_serial #(.WIDTH(16), .LIMB(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
  mod_addsub_serial dut256 (.clk(clk), .rst_n(rst_n), .bus(i256));

  function automatic logic [255:0] ref_mod(input logic sub, input logic [255:0] a, b, p);
    logic [256:0] x;
    if (sub) x = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, p} - {1'b0, b};
    else begin
      x = {1'b0, a} + {1'b0, b};
      if (x >= {1'b0, p}) x = x - {1'b0, p};
    end
    return x[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive16(input logic op, input logic [15:0] a, b, p);
    i16.start = 1'b1; i16.op_sub = op; i16.a = a; i16.b = b; i16.p = p;
  endtask

  // Start sampled on the next posedge; operands are scrambled afterwards.
  task automatic launch16(input logic op, input logic [15:0] a, b, p);
    @(negedge clk); drive16(op, a, b, p);
    @(negedge clk); i16.start = 1'b0;
    i16.a = 16'($urandom); i16.b = 16'($urandom); i16.p = 16'($urandom); i16.op_sub = ~op;
  endtask

  task automatic wait16(input int c0, output int cyc, output int bcnt, output int busy_at_done);
    cyc = c0; bcnt = 0;
    while (i16.done !== 1'b1 && cyc < 200) begin
      if (i16.busy === 1'b1) bcnt++;
      @(negedge clk); cyc++;
    end
    busy_at_done = int'(i16.busy);
  endtask

  task automatic launch256(input logic op, input logic [255:0] a, b);
    @(negedge clk);
    i256.start = 1'b1; i256.op_sub = op; i256.a = a; i256.b = b; i256.p = P256_P;
    @(negedge clk); i256.start = 1'b0;
    i256.a = rand256(); i256.b = rand256(); i256.p = rand256();
  endtask

  task automatic wait256(output int cyc);
    cyc = 1;
    while (i256.done !== 1'b1 && cyc < 400) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    i16.start = 0; i16.op_sub = 0; i16.a = 0; i16.b = 0; i16.p = 0;
    i256.start = 0; i256.op_sub = 0; i256.a = 0; i256.b = 0; i256.p = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (i16.busy !== 1'b0) begin failures++; $display("FAIL reset_busy16: got %b want 0", i16.busy); end
    checks++; if (i16.done !== 1'b0) begin failures++; $display("FAIL reset_done16: got %b want 0", i16.done); end
    checks++; if (i16.result !== 16'h0) begin failures++; $display("FAIL reset_result16: got %h want 0", i16.result); end
    checks++; if (i256.result !== 256'h0 || i256.done !== 1'b0) begin failures++; $display("FAIL reset_256: result %h done %b", i256.result, i256.done); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    int cyc, bcnt, bd;
    launch16(OP_ADD, 16'h1234, 16'h0001, P16);
    wait16(1, cyc, bcnt, bd);
    checks++; if (i16.result !== 16'h1235) begin failures++; $display("FAIL add_basic_result: got %h want 1235", i16.result); end
    checks++; if (cyc != NL16 + 1) begin failures++; $display("FAIL add_basic_latency: got %0d want %0d", cyc, NL16 + 1); end
    checks++; if (bcnt != NL16) begin failures++; $display("FAIL add_basic_busy_cycles: got %0d want %0d", bcnt, NL16); end
    checks++; if (bd != 0) begin failures++; $display("FAIL add_basic_busy_at_done: got %0d want 0", bd); end
    @(negedge clk);
    checks++; if (i16.done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b want 0", i16.done); end
    checks++; if (i16.result !== 16'h1235) begin failures++; $display("FAIL result_hold: got %h want 1235", i16.result); end
  endtask

  task automatic test_directed16();
    logic        op  [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [15:0] va  [4] = '{16'hFFF0, 16'hFFF0, 16'h0003, 16'h1234};
    logic [15:0] vb  [4] = '{16'hFFF0, 16'h0005, 16'h0005, 16'h1234};
    logic [15:0] exp [4] = '{16'hFFEF, 16'h0004, 16'hFFEF, 16'h0000};
    int cyc, bcnt, bd;
    for (int i = 0; i < 4; i++) begin
      launch16(op[i], va[i], vb[i], P16);
      wait16(1, cyc, bcnt, bd);
      checks++; if (i16.result !== exp[i] || cyc != NL16 + 1) begin
        failures++; $display("FAIL directed16_%0d: got %h lat %0d want %h lat %0d", i, i16.result, cyc, exp[i], NL16 + 1);
      end
    end
  endtask

  task automatic test_random16();
    int cyc, bcnt, bd;
    logic [15:0] p, a, b, exp;
    logic op;
    for (int i = 0; i < 24; i++) begin
      p = 16'($urandom_range(2, 65535));
      if (i % 3 == 0) p = P16;
      a = 16'($urandom % p); b = 16'($urandom % p);
      if (i == 5) b = p - a - 16'd1;
      op = 1'($urandom);
      exp = 16'(ref_mod(op, 256'(a), 256'(b), 256'(p)));
      launch16(op, a, b, p);
      wait16(1, cyc, bcnt, bd);
      checks++; if (i16.result !== exp || cyc != NL16 + 1) begin
        failures++; $display("FAIL random16_%0d: op %b a %h b %h p %h got %h want %h lat %0d", i, op, a, b, p, i16.result, exp, cyc);
      end
    end
  endtask

  task automatic test_p256();
    int cyc;
    logic [255:0] a, b, exp;
    logic op;
    launch256(OP_ADD, P256_P - 256'd1, 256'd1);
    wait256(cyc);
    checks++; if (i256.result !== 256'h0) begin failures++; $display("FAIL p256_add_wrap: got %h want 0", i256.result); end
    checks++; if (cyc != NL256 + 1) begin failures++; $display("FAIL p256_latency: got %0d want %0d", cyc, NL256 + 1); end
    launch256(OP_SUB, 256'd0, 256'd1);
    wait256(cyc);
    checks++; if (i256.result !== P256_P - 256'd1) begin failures++; $display("FAIL p256_sub_under: got %h want %h", i256.result, P256_P - 256'd1); end
    for (int i = 0; i < 6; i++) begin
      a = rand256(); if (a >= P256_P) a = a - P256_P;
      b = rand256(); if (b >= P256_P) b = b - P256_P;
      op = 1'(i % 2);
      exp = ref_mod(op, a, b, P256_P);
      launch256(op, a, b);
      wait256(cyc);
      checks++; if (i256.result !== exp || cyc != NL256 + 1) begin
        failures++; $display("FAIL p256_random_%0d: got %h want %h lat %0d", i, i256.result, exp, cyc);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcnt, bd;
    launch16(OP_ADD, 16'h0100, 16'h0023, P16);
    @(negedge clk); drive16(OP_SUB, 16'h7777, 16'h1111, 16'h9999);
    @(negedge clk); i16.start = 1'b0;
    wait16(3, cyc, bcnt, bd);
    checks++; if (i16.result !== 16'h0123) begin failures++; $display("FAIL ignore_start_result: got %h want 0123", i16.result); end
    checks++; if (cyc != NL16 + 1) begin failures++; $display("FAIL ignore_start_latency: got %0d want %0d", cyc, NL16 + 1); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt, bd;
    launch16(OP_SUB, 16'h0010, 16'h0020, P16);
    wait16(1, cyc, bcnt, bd);
    checks++; if (i16.result !== 16'hFFE1) begin failures++; $display("FAIL b2b_first: got %h want ffe1", i16.result); end
    drive16(OP_ADD, 16'h4000, 16'h2345, P16);
    @(negedge clk); i16.start = 1'b0; i16.a = 16'hDEAD;
    wait16(1, cyc, bcnt, bd);
    checks++; if (i16.result !== 16'h6345) begin failures++; $display("FAIL b2b_second: got %h want 6345", i16.result); end
    checks++; if (cyc != NL16 + 1) begin failures++; $display("FAIL b2b_latency: got %0d want %0d", cyc, NL16 + 1); end
  endtask

  task automatic test_reset_mid();
    int cyc, bcnt, bd, spurious;
    launch16(OP_ADD, 16'h0A0A, 16'h0505, P16);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (i16.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", i16.busy); end
    checks++; if (i16.done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b want 0", i16.done); end
    checks++; if (i16.result !== 16'h0) begin failures++; $display("FAIL midreset_result: got %h want 0", i16.result); end
    @(negedge clk); rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < NL16 + 3; i++) begin
      @(negedge clk);
      if (i16.done === 1'b1 || i16.busy === 1'b1) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL midreset_spurious: got %0d active cycles want 0", spurious); end
    launch16(OP_SUB, 16'h5555, 16'h1111, P16);
    wait16(1, cyc, bcnt, bd);
    checks++; if (i16.result !== 16'h4444 || cyc != NL16 + 1) begin
      failures++; $display("FAIL midreset_recover: got %h lat %0d want 4444 lat %0d", i16.result, cyc, NL16 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_directed16();
    test_random16();
    test_p256();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_addsub_serial.md
Name: mod_addsub_serial

Overview:
- Parametrised, limb-serial modular adder/subtractor for the ECC field datapath: computes (a + b) mod p or (a − b) mod p on WIDTH-bit operands, LIMB bits per cycle.
- Successor to the fixed 256-bit flat ripple adder. Adds a start/done handshake, operand latching, a selectable add/sub mode and in-line modular reduction.
- Sits between the point-arithmetic controller and the operand register file.

Parameters:
- WIDTH, 256, operand/modulus width in bits.
- LIMB, 8, bits processed per cycle; must divide WIDTH (elaboration error otherwise).
- NL, WIDTH/LIMB (derived localparam, not overridable), number of limb cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op_sub  in  1  0 = modular add, 1 = modular subtract; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- p  in  WIDTH  modulus; latched with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  reduced result; held until the next accepted start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal operand, partial and carry registers 0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1, latch a, b, p and op_sub; clear limb index k, carry c1 and carry c2; go to RUN.
  - start=0 → stay in IDLE.
- RUN, one limb per cycle, k = 0..NL−1, limb slice [k*LIMB +: LIMB]:
  - add: s_k = a_k + b_k + c1. Then t_k = s_k − p_k − borrow2, where borrow2 is kept in c2.
  - sub: s_k = a_k − b_k − borrow1, with borrow1 kept in c1. Then t_k = s_k + p_k + c2.
  - The s and t chains run in the same cycle; the t chain consumes the freshly computed s_k.
  - s_k and t_k are written into WIDTH-bit shift/slot registers S and T.
  - At k = NL−1, go to FIN.
- FIN, select stage:
  - add: result = T if (c1 = 1 or final borrow2 = 0), else S.
  - sub: result = T if final borrow1 = 1, else S.
  - done=1 for this single cycle; busy=0 in this cycle; go to IDLE.
- Latency: done is asserted exactly NL+1 cycles after the cycle in which start was sampled high (P-256 default: 33 cycles).
- busy is high during the RUN cycles only.
- Back-to-back: start asserted in the FIN/done cycle is accepted. The next operation's done comes NL+1 cycles later.
- start while in RUN is ignored; latched operands are unaffected.
- a, b, p may change freely after acceptance.
- Precondition: a < p and b < p. If violated, result is unspecified but still WIDTH bits, and the done timing is unchanged. No error flag.
- a = b in sub mode gives 0. A sum exactly equal to p gives 0.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- All arithmetic is unsigned. Limb sums are LIMB+1 bits; only the carry/borrow bit propagates between cycles.

Decomposition:
- Package ecc_arith_pkg holds:
  - OP_ADD/OP_SUB constants.
  - FSM state enum.
  - P256_P constant for benches and integration.
  - Default WIDTH/LIMB values.
- Sub-module limb_addsub, combinational: LIMB-bit add or subtract with carry/borrow in and out, mode input. Instantiated twice, once for the S chain and once for the T chain.

Test Plan:
- WIDTH=16, LIMB=4, p=0xFFF1, add a=0x1234, b=0x0001 → result 0x1235. done exactly 5 cycles after start; busy high for 4 cycles.
- Same config, add a=0xFFF0, b=0xFFF0 (carry out of 2^16) → 0xFFEF. Also add a=0xFFF0, b=0x0005 → 0x0004.
- Same config, sub a=0x0003, b=0x0005 → 0xFFEF. Sub a=0x1234, b=0x1234 → 0x0000.
- Default config, P-256 p: add a=p−1, b=1 → 0; sub a=0, b=1 → p−1. done 33 cycles after start.
- Handshake: start pulsed again during RUN with different operands → ignored, first result returned. Start in the done cycle → accepted, second done NL+1 cycles later.
- Reset: rst_n low mid-RUN (k=2) → busy=0, done=0, result=0 immediately; no spurious done. A fresh start afterwards completes correctly.
